// File: rtl/axi4_rd_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port (AR + R) between NM masters.
// Latency: 1 cycle arbitration (IDLE), then AR forwarded combinationally, R beats forwarded combinationally.
// Backpressure: s_arready -> granted m_arready, granted m_rready -> s_rready; non-granted masters see 0.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   m_ar*  / m_arvalid / m_arready per-master AR channels, master i at slice i
//   m_r*   / m_rvalid  / m_rready  shared R payload, per-master valid/ready
//   s_ar*  / s_arvalid / s_arready downstream AR channel
//   s_r*   / s_rvalid  / s_rready  downstream R channel
//   grant_id, busy, burst_err      status: current grant, non-IDLE, sticky RLAST/ARLEN mismatch
module axi4_rd_rr_arbiter #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  // master-side AR
  input  logic [NM*AW-1:0]   m_araddr,
  input  logic [NM*4-1:0]    m_arid,
  input  logic [NM*8-1:0]    m_arlen,
  input  logic [NM*3-1:0]    m_arsize,
  input  logic [NM*2-1:0]    m_arburst,
  input  logic [NM-1:0]      m_arvalid,
  output logic [NM-1:0]      m_arready,
  // master-side R
  output logic [3:0]         m_rid,
  output logic [DW-1:0]      m_rdata,
  output logic [1:0]         m_rresp,
  output logic               m_rlast,
  output logic [NM-1:0]      m_rvalid,
  input  logic [NM-1:0]      m_rready,
  // downstream AR
  output logic [AW-1:0]      s_araddr,
  output logic [3:0]         s_arid,
  output logic [7:0]         s_arlen,
  output logic [2:0]         s_arsize,
  output logic [1:0]         s_arburst,
  output logic               s_arvalid,
  input  logic               s_arready,
  // downstream R
  input  logic [3:0]         s_rid,
  input  logic [DW-1:0]      s_rdata,
  input  logic [1:0]         s_rresp,
  input  logic               s_rlast,
  input  logic               s_rvalid,
  output logic               s_rready,
  // status
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic               burst_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] rr_q, rr_d;
  logic [7:0] beat_q, beat_d;
  logic       err_q, err_d;

  // Per-master payloads unpacked into fixed 4-entry arrays so a 2-bit grant
  // index selects cleanly for any NM in 2..4; unused entries read as zero.
  logic [AW-1:0] addr_a  [4];
  logic [3:0]    id_a    [4];
  logic [7:0]    len_a   [4];
  logic [2:0]    size_a  [4];
  logic [1:0]    burst_a [4];
  logic [3:0]    arv_ext;
  logic [3:0]    rrdy_ext;

  assign arv_ext  = 4'(m_arvalid);
  assign rrdy_ext = 4'(m_rready);

  for (genvar i = 0; i < 4; i++) begin : g_unpack
    if (i < NM) begin : g_on
      assign addr_a[i]  = m_araddr[i*AW +: AW];
      assign id_a[i]    = m_arid[i*4 +: 4];
      assign len_a[i]   = m_arlen[i*8 +: 8];
      assign size_a[i]  = m_arsize[i*3 +: 3];
      assign burst_a[i] = m_arburst[i*2 +: 2];
    end else begin : g_off
      assign addr_a[i]  = '0;
      assign id_a[i]    = '0;
      assign len_a[i]   = '0;
      assign size_a[i]  = '0;
      assign burst_a[i] = '0;
    end
  end

  // Round-robin pick: scan rr_q, rr_q+1, ... mod NM. The scan runs from the
  // farthest offset down so the nearest requester is written last and wins.
  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [2:0] scan_sum;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    scan_sum = 3'd0;
    for (int k = NM - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_q} + 3'(k);
      if (scan_sum >= 3'(NM)) scan_sum = scan_sum - 3'(NM);
      if (arv_ext[scan_sum[1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan_sum[1:0];
      end
    end
  end

  // Pointer advances past the master just served once its burst ends.
  logic [2:0] grant_inc;
  logic [1:0] rr_after;

  always_comb begin
    grant_inc = {1'b0, grant_q} + 3'd1;
    rr_after  = (grant_inc == 3'(NM)) ? 2'd0 : grant_inc[1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      rr_q    <= 2'd0;
      beat_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  logic ar_hs;
  logic r_hs;

  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid & s_rready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) begin
          beat_d  = s_arlen;
          state_d = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          beat_d = (beat_q == 8'd0) ? 8'd0 : beat_q - 8'd1;
          // beat_q == 0 means this should be the final beat.
          if (s_rlast != (beat_q == 8'd0)) err_d = 1'b1;
          if (s_rlast) begin
            state_d = IDLE;
            rr_d    = rr_after;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: everything is gated by the registered state, so a request
  // seen in IDLE is never forwarded in the same cycle.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rid     = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rlast   = 1'b0;
    s_araddr  = '0;
    s_arid    = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    case (state_q)
      ADDR: begin
        s_araddr  = addr_a[grant_q];
        s_arid    = id_a[grant_q];
        s_arlen   = len_a[grant_q];
        s_arsize  = size_a[grant_q];
        s_arburst = burst_a[grant_q];
        s_arvalid = arv_ext[grant_q];
        for (int i = 0; i < NM; i++) begin
          if (grant_q == 2'(i)) m_arready[i] = s_arready;
        end
      end
      DATA: begin
        m_rid    = s_rid;
        m_rdata  = s_rdata;
        m_rresp  = s_rresp;
        m_rlast  = s_rlast;
        s_rready = rrdy_ext[grant_q];
        for (int i = 0; i < NM; i++) begin
          if (grant_q == 2'(i)) m_rvalid[i] = s_rvalid;
        end
      end
      default: ;
    endcase
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);
  assign burst_err = err_q;

endmodule

// File: tb/tb_axi4_rd_rr_arbiter.sv
module tb_axi4_rd_rr_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NM*AW-1:0] m_araddr;
  logic [NM*4-1:0]  m_arid;
  logic [NM*8-1:0]  m_arlen;
  logic [NM*3-1:0]  m_arsize;
  logic [NM*2-1:0]  m_arburst;
  logic [NM-1:0]    m_arvalid;
  logic [NM-1:0]    m_arready;
  logic [3:0]       m_rid;
  logic [DW-1:0]    m_rdata;
  logic [1:0]       m_rresp;
  logic             m_rlast;
  logic [NM-1:0]    m_rvalid;
  logic [NM-1:0]    m_rready;
  logic [AW-1:0]    s_araddr;
  logic [3:0]       s_arid;
  logic [7:0]       s_arlen;
  logic [2:0]       s_arsize;
  logic [1:0]       s_arburst;
  logic             s_arvalid;
  logic             s_arready;
  logic [3:0]       s_rid;
  logic [DW-1:0]    s_rdata;
  logic [1:0]       s_rresp;
  logic             s_rlast;
  logic             s_rvalid;
  logic             s_rready;
  logic [1:0]       grant_id;
  logic             busy;
  logic             burst_err;

  int vectors = 0;
  int errors  = 0;

  axi4_rd_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant_id(grant_id), .busy(busy), .burst_err(burst_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int hs;
  int beat;

  initial begin
    rst_n = 1'b0;
    m_araddr = '0; m_arid = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    m_arvalid = '0; m_rready = '0;
    s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    #1;
    // ---- reset state
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_err", burst_err, 0);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_m_arready", m_arready, 0);
    chk("rst_s_rready", s_rready, 0);
    #12 rst_n = 1'b1;
    step();

    // ---- single request, master 0, arlen 0
    m_araddr[0 +: AW] = 32'h8000_0000;
    m_arid[0 +: 4] = 4'h3; m_arsize[0 +: 3] = 3'd2; m_arburst[0 +: 2] = 2'b01;
    m_arlen[0 +: 8] = 8'd0;
    m_arvalid = 2'b01;
    #1;
    chk("single_idle_no_fwd", s_arvalid, 0);
    chk("single_idle_no_rdy", m_arready, 0);
    step();
    chk("single_addr_vld", s_arvalid, 1);
    chk("single_addr", s_araddr, 32'h8000_0000);
    chk("single_arid", s_arid, 4'h3);
    chk("single_busy", busy, 1);
    chk("single_rdy_stalled", m_arready, 2'b00);
    s_arready = 1'b1;
    #1;
    chk("single_rdy", m_arready, 2'b01);
    step();
    m_arvalid = 2'b00; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rid = 4'h3; m_rready = 2'b01;
    #1;
    chk("single_rvalid", m_rvalid, 2'b01);
    chk("single_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("single_rlast", m_rlast, 1);
    chk("single_rid", m_rid, 4'h3);
    chk("single_s_rready", s_rready, 1);
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    chk("single_busy_drop", busy, 0);
    chk("single_rdata_idle", m_rdata, 0);
    chk("single_err", burst_err, 0);

    // ---- burst, master 1, arlen 3, rready toggling
    m_araddr[AW +: AW] = 32'h0000_1000;
    m_arlen[8 +: 8] = 8'd3;
    m_arvalid = 2'b10;
    s_arready = 1'b1;
    step();
    chk("burst_grant", grant_id, 1);
    chk("burst_arready", m_arready, 2'b10);
    chk("burst_addr", s_araddr, 32'h0000_1000);
    chk("burst_arlen", s_arlen, 8'd3);
    step();
    m_arvalid = 2'b00; s_arready = 1'b0;
    hs = 0; beat = 0;
    for (int c = 0; c < 20 && busy; c++) begin
      // master 0 always ready: it must not affect the granted master's flow
      m_rready = (c % 2 == 0) ? 2'b11 : 2'b01;
      s_rvalid = 1'b1;
      s_rdata  = 32'h100 + beat;
      s_rlast  = (beat == 3);
      #1;
      chk("burst_rvalid", m_rvalid, 2'b10);
      chk("burst_s_rready", s_rready, m_rready[1]);
      chk("burst_rdata", m_rdata, 32'h100 + beat);
      if (m_rready[1]) begin
        hs++;
        beat++;
      end
      step();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = 2'b00;
    #1;
    chk("burst_handshakes", hs, 4);
    chk("burst_done", busy, 0);
    chk("burst_no_err", burst_err, 0);

    // ---- fairness: both masters request continuously, rr_ptr back at 0
    m_araddr[0 +: AW] = 32'h0000_00A0;
    m_araddr[AW +: AW] = 32'h0000_00B0;
    m_arlen = '0;
    m_arvalid = 2'b11;
    s_arready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("fair_grant", grant_id, t % 2);
      chk("fair_arready", m_arready, (t % 2 == 0) ? 2'b01 : 2'b10);
      chk("fair_addr", s_araddr, (t % 2 == 0) ? 32'hA0 : 32'hB0);
      step();
      s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 2'b11;
      step();
      s_rvalid = 1'b0; s_rlast = 1'b0;
    end
    m_arvalid = 2'b00; s_arready = 1'b0; m_rready = 2'b00;
    #1;
    chk("fair_idle", busy, 0);

    // ---- burst mismatch: arlen 3, rlast on third beat (index 2)
    m_arlen[0 +: 8] = 8'd3;
    m_arvalid = 2'b01;
    s_arready = 1'b1;
    step();
    chk("mis_grant", grant_id, 0);
    step();
    m_arvalid = 2'b00; s_arready = 1'b0;
    m_rready = 2'b01; s_rvalid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      s_rlast = (b == 2);
      #1;
      chk("mis_err_before", burst_err, 0);
      step();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = 2'b00;
    #1;
    chk("mis_idle", busy, 0);
    chk("mis_err", burst_err, 1);
    repeat (3) step();
    chk("mis_err_sticky", burst_err, 1);

    // ---- reset mid-DATA: master 1, arlen 3, reset after beat 1
    m_arlen[8 +: 8] = 8'd3;
    m_arvalid = 2'b10;
    s_arready = 1'b1;
    step();
    chk("rstd_grant", grant_id, 1);
    step();
    m_arvalid = 2'b00; s_arready = 1'b0;
    m_rready = 2'b10; s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = 32'h5555_AAAA;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rstd_rvalid", m_rvalid, 0);
    chk("rstd_s_rready", s_rready, 0);
    chk("rstd_rdata", m_rdata, 0);
    chk("rstd_busy", busy, 0);
    chk("rstd_err", burst_err, 0);
    chk("rstd_grant0", grant_id, 0);
    s_rvalid = 1'b0; m_rready = 2'b00;
    #3 rst_n = 1'b1;
    step();
    chk("rstd_post_busy", busy, 0);
    chk("rstd_post_grant", grant_id, 0);

    // ---- stall: both request, s_arready low for 10 cycles; rr_ptr reset to 0
    m_arvalid = 2'b11;
    step();
    for (int c = 0; c < 10; c++) begin
      chk("stall_grant", grant_id, 0);
      chk("stall_arready", m_arready, 2'b00);
      chk("stall_arvalid", s_arvalid, 1);
      step();
    end
    s_arready = 1'b1;
    #1;
    chk("stall_release_rdy", m_arready, 2'b01);
    step();
    s_arready = 1'b0;
    s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 2'b11;
    step();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    step();
    chk("stall_next_grant", grant_id, 1);
    chk("stall_next_arready", m_arready, 2'b00);
    m_arvalid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/axi4_rd_rr_arbiter.md
Name: axi4_rd_rr_arbiter

Overview:
- Round-robin arbiter for the AXI4 read path (AR and R channels) that shares one downstream read port between NM masters, e.g. IFU, LSU and a future DMA.
- Arbitration is registered, one transaction at a time, with burst support.
- It sits between the masters' read ports and the SoC read port.
- Write channels are not handled by this block.

Parameters:
- NM, 2, number of masters (2..4).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_araddr  in  NM*AW  per-master AR address, master i in slice [i*AW +: AW]
- m_arid  in  NM*4  per-master ARID
- m_arlen  in  NM*8  per-master ARLEN
- m_arsize  in  NM*3  per-master ARSIZE
- m_arburst  in  NM*2  per-master ARBURST
- m_arvalid  in  NM  per-master ARVALID
- m_arready  out  NM  per-master ARREADY
- m_rid  out  4  shared RID, meaningful only where m_rvalid is set
- m_rdata  out  DW  shared RDATA
- m_rresp  out  2  shared RRESP
- m_rlast  out  1  shared RLAST
- m_rvalid  out  NM  per-master RVALID
- m_rready  in  NM  per-master RREADY
- s_araddr/s_arid/s_arlen/s_arsize/s_arburst  out  AW/4/8/3/2  downstream AR payload
- s_arvalid  out  1  downstream ARVALID
- s_arready  in  1  downstream ARREADY
- s_rid/s_rdata/s_rresp/s_rlast  in  4/DW/2/1  downstream R payload
- s_rvalid  in  1  downstream RVALID
- s_rready  out  1  downstream RREADY
- grant_id  out  2  index of the currently granted master
- busy  out  1  high whenever state is not IDLE
- burst_err  out  1  sticky RLAST/ARLEN mismatch flag

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, burst_err=0.
  - All valid and ready outputs are 0; all payload outputs are 0.
  - Reset mid-burst aborts the burst with no drain.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Nothing is forwarded: s_arvalid=0, s_rready=0, m_arready=0.
  - If any m_arvalid is set, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod NM.
  - Register it into grant_id and go to ADDR. Arbitration costs exactly 1 cycle.
- ADDR:
  - s_ar* = payload of grant_id.
  - s_arvalid = m_arvalid[grant_id]; m_arready[grant_id] = s_arready; other m_arready = 0.
  - On s_arvalid & s_arready: load beat_cnt <= s_arlen and go to DATA.
  - Masters must hold ARVALID until the handshake; dropping it is unchecked and the FSM stays in ADDR.
- DATA:
  - m_rvalid[grant_id] = s_rvalid; other m_rvalid bits = 0.
  - s_rready = m_rready[grant_id]; m_rid/rdata/rresp/rlast = s_r* unmodified.
  - On each s_rvalid & s_rready beat: beat_cnt decrements, saturating at 0.
  - A beat with s_rlast=1 ends the transaction: state=IDLE, rr_ptr <= (grant_id+1) mod NM.
  - Set burst_err on a beat with s_rlast=1 and beat_cnt!=0, or s_rlast=0 and beat_cnt==0.
  - Transaction end is decided by s_rlast regardless of burst_err.
- burst_err clears only on reset.
- Handshakes arriving in the same cycle as state changes follow the current-state rules above; no combinational path crosses from IDLE to forwarding.
- m_r* payload outputs are 0 in IDLE and ADDR.
- Back-to-back throughput: IDLE→ADDR→DATA, 1 dead cycle (IDLE) between transactions.
- A master that keeps requesting waits at most NM-1 transactions (no starvation).
- Width rules:
  - grant_id is zero-extended to 2 bits.
  - beat_cnt is 8 bits, so ARLEN=255 gives 256 beats.
  - rr_ptr wraps modulo NM.

Test Plan:
- Single request: m_arvalid=01, addr 0x8000_0000, arlen=0 → s_arvalid rises 1 cycle after the request; one beat returned to master 0 with rlast; busy drops the next cycle.
- Burst: master 1, arlen=3, slave returns 4 beats with rready toggling → only m_rvalid[1] pulses, exactly 4 handshakes occur, burst_err=0.
- Fairness: both masters hold arvalid for 4 transactions → grant order 0,1,0,1 starting from rr_ptr=0.
- Burst mismatch: arlen=3 but slave asserts rlast on beat 2 → FSM returns to IDLE and burst_err=1 stays high until reset.
- Reset mid-DATA: rst_n pulled low after beat 1 of 4 → all outputs 0 immediately; after release, state=IDLE and grant_id=0.
- Stall: s_arready held 0 for 10 cycles while both masters request → grant stays fixed and m_arready=0 for the non-granted master throughout.
